// File: rtl/shift_frame_sequencer.sv
// shift_frame_sequencer: arbitrates two byte requesters onto one 8-bit shift
// register, serializes the granted byte into it one bit per clock, then
// captures the register's parallel output and returns it with a valid strobe.
module shift_frame_sequencer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       ack,
  output logic             sr_in,
  output logic             sr_shift,
  input  logic [WIDTH-1:0] sr_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             grant_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gap_cnt;
  logic             last_grant;
  logic             grant_sel;
  logic [WIDTH-1:0] sel_data;

  // Returns the bit of v that goes on the wire in shift cycle k (0-based).
  function automatic logic pick(input logic [WIDTH-1:0] v, input int k);
    int idx;
    idx = MSB_FIRST ? (WIDTH - 1 - k) : k;
    return v[idx[CW-1:0]];
  endfunction

  // Round-robin choice: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    grant_sel = req[1] & (~req[0] | ~last_grant);
    sel_data  = grant_sel ? data1 : data0;
  end

  // Frame state machine; every output is a flop so the shift register sees clean levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      hold       <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      ack        <= 2'b00;
      sr_in      <= 1'b0;
      sr_shift   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
    end else begin
      ack      <= 2'b00;
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            hold       <= sel_data;
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
            cnt        <= '0;
            ack        <= grant_sel ? 2'b10 : 2'b01;
            sr_shift   <= 1'b1;
            sr_in      <= pick(sel_data, 0);
            busy       <= 1'b1;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            sr_shift <= 1'b0;
            sr_in    <= 1'b0;
            state    <= S_CAPTURE;
          end else begin
            sr_in <= pick(hold, int'(cnt) + 1);
          end
        end
        S_CAPTURE: begin
          rx_data  <= sr_out;
          rx_valid <= 1'b1;
          if (GAP > 0) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          sr_shift <= 1'b0;
          sr_in    <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_frame_sequencer.md
Name: shift_frame_sequencer

Overview:
- Sequences the 8-bit ShiftRegister datapath: arbitrates two byte requesters onto the single shift register, then serializes the granted byte into its serial input one bit per clock.
- After the last bit it captures the register's parallel output and returns it with a one-cycle valid strobe.
- Sits between requester logic and the ShiftRegister instance; drives its serial input and shift enable and reads its out bus.

Parameters:
- WIDTH, 8, bits per frame; matches the ShiftRegister out width.
- GAP, 1, idle cycles inserted after each frame before the next arbitration (0 allowed).
- MSB_FIRST, 1, 1 = serialize bit WIDTH-1 first, 0 = bit 0 first.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  2  per-requester request, level; held until its ack.
- data0  input  WIDTH  requester 0 byte, stable while req[0]=1.
- data1  input  WIDTH  requester 1 byte, stable while req[1]=1.
- ack  output  2  one-cycle pulse: the byte was accepted.
- sr_in  output  1  serial bit to the ShiftRegister in.
- sr_shift  output  1  shift enable to the ShiftRegister; high for exactly WIDTH cycles per frame.
- sr_out  input  WIDTH  parallel output of the ShiftRegister.
- rx_data  output  WIDTH  captured sr_out value for the last frame.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- busy  output  1  high whenever state is not IDLE.
- grant_id  output  1  requester owning the current frame; meaningful only while busy=1.

Behaviour:
- Reset (async, reset=0): state=IDLE, ack=0, sr_in=0, sr_shift=0, rx_data=0, rx_valid=0, busy=0, grant_id=0, bit counter=0, gap counter=0, last_grant=1 so requester 0 wins the first tie. Outputs go low immediately, without waiting for a clock edge.
- Reset asserted mid-frame aborts the frame. No rx_valid is produced and no ack is repeated. After release the sequencer restarts from IDLE.
- States are IDLE, SHIFT, CAPTURE and GAP. All outputs are registered.
- IDLE: on a rising edge with req!=0, grant a requester:
  - If only one requests, it wins.
  - If both request, the one that is not last_grant wins (round-robin).
  - On that edge: latch its data into a hold register, set grant_id and last_grant, clear the bit counter, go to SHIFT, and drive ack[grant]=1 for the next cycle only.
- SHIFT:
  - sr_shift=1.
  - sr_in = hold[WIDTH-1-cnt] if MSB_FIRST=1, else hold[cnt].
  - cnt increments every cycle.
  - On the edge where cnt==WIDTH-1, go to CAPTURE. The ShiftRegister has then sampled exactly WIDTH bits.
- CAPTURE:
  - sr_shift=0 and sr_in=0.
  - On the edge: rx_data<=sr_out, rx_valid=1 for the following cycle.
  - Next state is GAP if GAP>0, else IDLE.
- GAP: hold for GAP cycles with sr_shift=0, then go to IDLE. Requests are not arbitrated during GAP.
- Frame latency: arbitration edge E. ack high in cycle E+1. sr_shift high in cycles E+1..E+WIDTH. CAPTURE in cycle E+WIDTH+1. rx_valid high in cycle E+WIDTH+2.
- Back-to-back requests: frame period is WIDTH+2+GAP cycles (11 with defaults).
- Requests during a frame: req changes on either line are ignored until IDLE. A requester dropping req mid-frame does not abort its frame. A request dropped before its grant is never acked.
- ack and rx_valid are never high for more than one consecutive cycle per frame.
- sr_shift is never high outside SHIFT.

Test Plan:
- Single frame: after reset, req=2'b01, data0=8'hA5, MSB_FIRST=1 -> ack=2'b01 for 1 cycle; sr_in sequence 1,0,1,0,0,1,0,1 over 8 sr_shift cycles; rx_valid one cycle later with rx_data=8'hA5 (ShiftRegister in loopback).
- Tie and round-robin: req=2'b11 held, data0=8'h3C, data1=8'hC3 -> grants in order 0,1,0,1; rx_data 3C,C3,3C,C3; frame starts 11 cycles apart.
- LSB-first: MSB_FIRST=0, data0=8'h01 -> sr_in=1 in the first sr_shift cycle, then 0 for the remaining 7.
- Reset mid-frame: reset=0 during the 4th shift cycle -> sr_shift, busy and ack go 0 before the next clock edge; no rx_valid; after release, req=2'b10 is granted with grant_id=1.
- GAP=0 with req0 held and req1 pulsed for 2 cycles during a frame -> only req0 frames occur, 10 cycles apart; ack[1] is never asserted.
- Requester drops req in the 2nd shift cycle -> frame completes with 8 sr_shift cycles and rx_valid; next IDLE with req=0 stays idle with busy=0.
